// File: rtl/imem_responder.sv
`default_nettype none
// ============================================================================
// Module   : imem_responder
// Brief    : Dual-read-port instruction memory with a fixed-latency response
//            pipeline and a write-only loader port. Optional macro IMEM_ERR_EN
//            adds the imem_err output (out-of-range or misaligned address).
// Revision : 1.0 - initial release
// ============================================================================
module imem_responder #(
    parameter int              XLEN        = 32,
    parameter int              DEPTH_WORDS = 1024,
    parameter int              LATENCY     = 1,
    parameter logic [XLEN-1:0] NOP_INSTR   = 32'hD503201F
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 imem_ren,
    input  logic [XLEN-1:0]      imem_addr0,
    input  logic [XLEN-1:0]      imem_addr1,
    output logic [XLEN-1:0]      imem_rdata0,
    output logic [XLEN-1:0]      imem_rdata1,
    output logic [1:0][XLEN-1:0] imem_pc,
    output logic                 imem_valid,
`ifdef IMEM_ERR_EN
    output logic                 imem_err,
`endif
    input  logic                 ld_we,
    input  logic [XLEN-1:0]      ld_addr,
    input  logic [XLEN-1:0]      ld_data
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [XLEN-1:0] mem [DEPTH_WORDS];

    logic w_in0;
    logic w_in1;
    logic w_ld_in;

    // Upper address bits must all be zero; an address never wraps onto the array.
    generate
        if (XLEN > AW + 2) begin : g_range_hi
            assign w_in0   = (imem_addr0[XLEN-1:AW+2] == '0);
            assign w_in1   = (imem_addr1[XLEN-1:AW+2] == '0);
            assign w_ld_in = (ld_addr[XLEN-1:AW+2] == '0);
        end else begin : g_range_full
            assign w_in0   = 1'b1;
            assign w_in1   = 1'b1;
            assign w_ld_in = 1'b1;
        end
    endgenerate

    logic w_ld_unused;
    assign w_ld_unused = ^ld_addr[1:0];

    logic [XLEN-1:0] w_rd0;
    logic [XLEN-1:0] w_rd1;
    assign w_rd0 = w_in0 ? mem[imem_addr0[AW+1:2]] : NOP_INSTR;
    assign w_rd1 = w_in1 ? mem[imem_addr1[AW+1:2]] : NOP_INSTR;

    // Reads above sample the pre-write contents, giving read-before-write on collisions.
    always_ff @(posedge clk) begin
        if (!reset && ld_we && w_ld_in) begin
            mem[ld_addr[AW+1:2]] <= ld_data;
        end
    end

    logic [LATENCY-1:0]            vld_q;
    logic [LATENCY-1:0][XLEN-1:0]  pc0_q;
    logic [LATENCY-1:0][XLEN-1:0]  pc1_q;
    logic [LATENCY-1:0][XLEN-1:0]  dat0_q;
    logic [LATENCY-1:0][XLEN-1:0]  dat1_q;

    // Element 0 of each chain is the incoming request, element k the output of stage k-1.
    logic [LATENCY:0]              vld_d;
    logic [LATENCY:0][XLEN-1:0]    pc0_d;
    logic [LATENCY:0][XLEN-1:0]    pc1_d;
    logic [LATENCY:0][XLEN-1:0]    dat0_d;
    logic [LATENCY:0][XLEN-1:0]    dat1_d;

    assign vld_d  = {vld_q,  imem_ren};
    assign pc0_d  = {pc0_q,  imem_addr0};
    assign pc1_d  = {pc1_q,  imem_addr1};
    assign dat0_d = {dat0_q, w_rd0};
    assign dat1_d = {dat1_q, w_rd1};

    // Payload only advances with a valid beat so bubbles leave the last response held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q  <= '0;
            pc0_q  <= '0;
            pc1_q  <= '0;
            dat0_q <= '0;
            dat1_q <= '0;
        end else begin
            for (int k = 0; k < LATENCY; k++) begin
                vld_q[k] <= vld_d[k];
                if (vld_d[k]) begin
                    pc0_q[k]  <= pc0_d[k];
                    pc1_q[k]  <= pc1_d[k];
                    dat0_q[k] <= dat0_d[k];
                    dat1_q[k] <= dat1_d[k];
                end
            end
        end
    end

    assign imem_valid  = vld_d[LATENCY];
    assign imem_rdata0 = dat0_d[LATENCY];
    assign imem_rdata1 = dat1_d[LATENCY];
    assign imem_pc     = {pc1_d[LATENCY], pc0_d[LATENCY]};

`ifdef IMEM_ERR_EN
    logic                 w_err_req;
    logic [LATENCY-1:0]   err_q;
    logic [LATENCY:0]     err_d;

    assign w_err_req = ~w_in0 | ~w_in1 | (|imem_addr0[1:0]) | (|imem_addr1[1:0]);
    assign err_d     = {err_q, w_err_req};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= '0;
        end else begin
            for (int k = 0; k < LATENCY; k++) begin
                err_q[k] <= vld_d[k] & err_d[k];
            end
        end
    end

    assign imem_err = err_d[LATENCY];
`endif

endmodule
`default_nettype wire

// File: tb/tb_imem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_responder
// Brief    : Scoreboard bench driving a LATENCY=1 and a LATENCY=3 responder in
//            parallel from one directed stimulus sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_responder;

    localparam logic [31:0] NOP   = 32'hD503201F;
    localparam logic [31:0] LIMIT = 32'h0000_1000;

    typedef struct {
        int          due;
        logic [31:0] p0;
        logic [31:0] p1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ren = 1'b0;
    logic [31:0] addr0 = '0;
    logic [31:0] addr1 = '0;
    logic        ld_we = 1'b0;
    logic [31:0] ld_addr = '0;
    logic [31:0] ld_data = '0;

    logic [31:0]      r0_a, r1_a, r0_b, r1_b;
    logic [1:0][31:0] pc_a, pc_b;
    logic             v_a, v_b;
    logic             err_a, err_b;

    always #5 clk = ~clk;

    imem_responder #(.XLEN(32), .DEPTH_WORDS(1024), .LATENCY(1), .NOP_INSTR(NOP)) u_dut1 (
        .clk(clk), .reset(reset), .imem_ren(ren), .imem_addr0(addr0), .imem_addr1(addr1),
        .imem_rdata0(r0_a), .imem_rdata1(r1_a), .imem_pc(pc_a), .imem_valid(v_a),
`ifdef IMEM_ERR_EN
        .imem_err(err_a),
`endif
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    imem_responder #(.XLEN(32), .DEPTH_WORDS(1024), .LATENCY(3), .NOP_INSTR(NOP)) u_dut3 (
        .clk(clk), .reset(reset), .imem_ren(ren), .imem_addr0(addr0), .imem_addr1(addr1),
        .imem_rdata0(r0_b), .imem_rdata1(r1_b), .imem_pc(pc_b), .imem_valid(v_b),
`ifdef IMEM_ERR_EN
        .imem_err(err_b),
`endif
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
    );

`ifndef IMEM_ERR_EN
    assign err_a = 1'b0;
    assign err_b = 1'b0;
`endif

    int          checks = 0;
    int          errors = 0;
    int          edge_n = 0;
    logic [31:0] tb_mem [1024];
    exp_t        q1 [$];
    exp_t        q3 [$];
    exp_t        l1;
    exp_t        l3;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s @edge %0d: observed=%h expected=%h", tag, edge_n, act, exp);
        end
    endtask

    function automatic logic [31:0] mread(input logic [31:0] a);
        return (a < LIMIT) ? tb_mem[a[11:2]] : NOP;
    endfunction

    function automatic logic bad(input logic [31:0] a);
        return (a >= LIMIT) || (a[1:0] != 2'b00);
    endfunction

    task automatic compare_dut(input string tag, input logic v, input exp_t e,
                               input logic av, input logic [31:0] ar0, input logic [31:0] ar1,
                               input logic [1:0][31:0] apc, input logic aerr);
        chk({tag, "_valid"}, {31'b0, av}, {31'b0, v});
        chk({tag, "_rdata0"}, ar0, e.d0);
        chk({tag, "_rdata1"}, ar1, e.d1);
        chk({tag, "_pc0"}, apc[0], e.p0);
        chk({tag, "_pc1"}, apc[1], e.p1);
`ifdef IMEM_ERR_EN
        chk({tag, "_err"}, {31'b0, aerr}, {31'b0, v & e.err});
`else
        if (aerr) errors++;
`endif
    endtask

    task automatic check_all();
        logic h1;
        logic h3;
        h1 = (q1.size() > 0) && (q1[0].due == edge_n);
        if (h1) l1 = q1.pop_front();
        h3 = (q3.size() > 0) && (q3[0].due == edge_n);
        if (h3) l3 = q3.pop_front();
        compare_dut("lat1", h1, l1, v_a, r0_a, r1_a, pc_a, err_a);
        compare_dut("lat3", h3, l3, v_b, r0_b, r1_b, pc_b, err_b);
    endtask

    task automatic clear_model();
        q1.delete();
        q3.delete();
        l1 = '{due: 0, p0: '0, p1: '0, d0: '0, d1: '0, err: 1'b0};
        l3 = l1;
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        edge_n++;
        if (!reset) begin
            if (ren) begin
                e.p0  = addr0;
                e.p1  = addr1;
                e.d0  = mread(addr0);
                e.d1  = mread(addr1);
                e.err = bad(addr0) || bad(addr1);
                e.due = edge_n;
                q1.push_back(e);
                e.due = edge_n + 2;
                q3.push_back(e);
            end
            if (ld_we && ld_addr < LIMIT) tb_mem[ld_addr[11:2]] = ld_data;
        end
        #1;
        check_all();
    endtask

    task automatic req(input logic [31:0] a0, input logic [31:0] a1);
        ren   = 1'b1;
        addr0 = a0;
        addr1 = a1;
        tick();
        ren   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) tb_mem[i] = '0;
        clear_model();

        // Reset state
        #1 reset = 1'b1;
        #2 check_all();
        idle(2);
        reset = 1'b0;

        // Load words 0..7
        for (int i = 0; i < 8; i++) begin
            ld_we   = 1'b1;
            ld_addr = 32'(4 * i);
            ld_data = 32'h1000_0000 + 32'(i);
            tick();
        end
        // Out-of-range loader writes must not alias onto word 0
        ld_addr = LIMIT;       ld_data = 32'hBADB_AD00; tick();
        ld_addr = 32'h8000_0000; ld_data = 32'hBADB_AD01; tick();
        ld_we = 1'b0;

        // Single request
        req(32'h0, 32'h4);
        idle(3);

        // Streaming, then a bubble that must hold the last payload
        for (int i = 0; i < 4; i++) begin
            ren   = 1'b1;
            addr0 = 32'(8 * i);
            addr1 = 32'(8 * i + 4);
            tick();
        end
        ren = 1'b0;
        idle(4);

        // Range and alignment boundaries
        req(LIMIT, 32'h2);
        req(32'h8000_0000, 32'h1C);
        req(32'h1, 32'h4);
        req(LIMIT - 32'h4, 32'h8);
        req(32'h14, 32'h18);
        idle(3);

        // Collision: read-before-write, both ports on the same word
        ld_we = 1'b1; ld_addr = 32'h8; ld_data = 32'hDEAD_BEEF;
        req(32'h8, 32'h8);
        ld_we = 1'b0;
        req(32'h8, 32'hC);
        idle(3);

        // Reset with two requests in flight on the LATENCY=3 instance
        req(32'h10, 32'h14);
        req(32'h18, 32'h1C);
        #2 reset = 1'b1;
        #1 clear_model();
        check_all();
        ld_we = 1'b1; ld_addr = 32'h10; ld_data = 32'hBAD0_BAD0; ren = 1'b1;
        idle(2);
        ld_we = 1'b0; ren = 1'b0;
        #2 reset = 1'b0;
        idle(4);
        req(32'h10, 32'h14);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
